// File: rtl/mult_pkg.sv
// Shared widths, types and FSM encoding for the sequential Booth multiplier.
package mult_pkg;

    // Default operand width and the widths derived from it.
    localparam int unsigned DW  = 8;
    localparam int unsigned DW2 = 2 * DW;
    localparam int unsigned EW  = DW + 1;
    localparam int unsigned CW  = $clog2(DW + 2);

    typedef logic [DW-1:0]  data_t;
    typedef logic [DW:0]    ext_t;
    typedef logic [DW2-1:0] product_t;
    typedef logic [CW-1:0]  count_t;

    typedef enum logic [1:0] {
        IDLE,
        BOOTH,
        DONE
    } state_t;

endpackage

// File: rtl/mult_booth_step.sv
// One combinational radix-2 Booth step: conditional add/subtract, then arithmetic shift right.
module mult_booth_step #(
    parameter int unsigned EW = mult_pkg::EW
) (
    input  logic [EW-1:0] a_i,
    input  logic [EW-1:0] q_i,
    input  logic          q_m1_i,
    input  logic [EW-1:0] m_i,
    output logic [EW-1:0] a_o,
    output logic [EW-1:0] q_o,
    output logic          q_m1_o
);

    logic [EW-1:0] sum;

    // Add/subtract from the Booth pair, then shift {A,Q,q_m1} right replicating A's MSB.
    always_comb begin
        sum = a_i;
        case ({q_i[0], q_m1_i})
            2'b01:   sum = a_i + m_i;
            2'b10:   sum = a_i - m_i;
            default: sum = a_i;
        endcase
        a_o    = {sum[EW-1], sum[EW-1:1]};
        q_o    = {sum[0], q_i[EW-1:1]};
        q_m1_o = q_i[0];
    end

endmodule

// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier with signed/unsigned mode and valid/ready on both sides.
module mult_booth_seq #(
    parameter int unsigned DW = mult_pkg::DW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            is_signed,
    input  logic [DW-1:0]   multiplicand,
    input  logic [DW-1:0]   multiplier,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] product,
    output logic            busy
);

    import mult_pkg::*;

    // Widths follow this instance's DW rather than the package default.
    localparam int unsigned DW2 = 2 * DW;
    localparam int unsigned EW  = DW + 1;
    localparam int unsigned CW  = $clog2(DW + 2);

    typedef logic [EW-1:0]  ext_t;
    typedef logic [DW2-1:0] product_t;
    typedef logic [CW-1:0]  count_t;

    state_t   state_q, state_d;
    ext_t     a_q, a_d;
    ext_t     qr_q, qr_d;
    ext_t     m_q, m_d;
    logic     qm1_q, qm1_d;
    count_t   cnt_q, cnt_d;
    product_t product_q, product_d;

    ext_t          a_s, qr_s;
    logic          qm1_s;
    logic [2*EW-1:0] full_s;

    mult_booth_step #(
        .EW(EW)
    ) u_step (
        .a_i   (a_q),
        .q_i   (qr_q),
        .q_m1_i(qm1_q),
        .m_i   (m_q),
        .a_o   (a_s),
        .q_o   (qr_s),
        .q_m1_o(qm1_s)
    );

    assign full_s = {a_s, qr_s};

    // State and datapath registers; synchronous reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            qr_q      <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            qr_q      <= qr_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    // Next-state: capture in IDLE, one Booth step per cycle, hold result until accepted.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        qr_d      = qr_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = '0;
                    qr_d    = {is_signed & multiplier[DW-1], multiplier};
                    m_d     = {is_signed & multiplicand[DW-1], multiplicand};
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = BOOTH;
                end
            end
            BOOTH: begin
                a_d   = a_s;
                qr_d  = qr_s;
                qm1_d = qm1_s;
                cnt_d = cnt_q + count_t'(1);
                // cnt_q == DW marks the (DW+1)th and final step.
                if (cnt_q == count_t'(DW)) begin
                    product_d = full_s[DW2-1:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BOOTH);
    assign product   = product_q;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Self-checking bench: DW=8 directed cases and a DW=16 randomised back-to-back regression.
module tb_mult_booth_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        iv8, ir8, s8, ov8, or8, busy8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;
    logic        iv16, ir16, s16, ov16, or16, busy16;
    logic [15:0] m16, q16;
    logic [31:0] p16;

    int checks = 0;
    int errors = 0;

    logic [15:0] sb8[$];
    logic [31:0] sb16[$];

    mult_booth_seq #(
        .DW(8)
    ) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (iv8),
        .in_ready    (ir8),
        .is_signed   (s8),
        .multiplicand(m8),
        .multiplier  (q8),
        .out_valid   (ov8),
        .out_ready   (or8),
        .product     (p8),
        .busy        (busy8)
    );

    mult_booth_seq #(
        .DW(16)
    ) u_dut16 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (iv16),
        .in_ready    (ir16),
        .is_signed   (s16),
        .multiplicand(m16),
        .multiplier  (q16),
        .out_valid   (ov16),
        .out_ready   (or16),
        .product     (p16),
        .busy        (busy16)
    );

    // Reference multiply of w-bit operands, returning the low 2w bits.
    function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q,
                                            input bit s, input int w);
        longint a, b, p;
        a = longint'(m);
        b = longint'(q);
        if (s && m[w-1]) a = a - (longint'(1) << w);
        if (s && q[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        p = p & ((longint'(1) << (2 * w)) - 1);
        return 32'(p);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single DW=8 operation with latency check, product check and output handshake.
    task automatic run_op8(input logic [7:0] m, input logic [7:0] q, input bit s,
                           input logic [15:0] want, input string name);
        int          lat;
        logic [15:0] exp;
        iv8 = 1'b1;
        m8  = m;
        q8  = q;
        s8  = s;
        sb8.push_back(want);
        checks++;
        if (ir8 !== 1'b1) begin
            errors++;
            $display("FAIL %s in_ready_before_accept got %b want 1", name, ir8);
        end
        tick();
        // Scramble inputs after capture; they must not disturb the operation.
        iv8 = 1'b0;
        m8  = 8'($urandom);
        q8  = 8'($urandom);
        s8  = ~s;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL %s latency got %0d want 9", name, lat);
        end
        exp = sb8.pop_front();
        checks++;
        if (p8 !== exp) begin
            errors++;
            $display("FAIL %s product got %h want %h", name, p8, exp);
        end
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        checks++;
        if ({ir8, ov8, p8} !== {1'b1, 1'b0, exp}) begin
            errors++;
            $display("FAIL %s after_handshake got ir=%b ov=%b p=%h want ir=1 ov=0 p=%h",
                     name, ir8, ov8, p8, exp);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({ir8, ov8, busy8, p8} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL reset8 got ir=%b ov=%b busy=%b p=%h want ir=1 ov=0 busy=0 p=0000",
                     ir8, ov8, busy8, p8);
        end
        checks++;
        if ({ir16, ov16, busy16, p16} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL reset16 got ir=%b ov=%b busy=%b p=%h want ir=1 ov=0 busy=0 p=0",
                     ir16, ov16, busy16, p16);
        end
    endtask

    task automatic test_corners;
        run_op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_80x80");
        run_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_FFxFF");
        run_op8(8'hFF, 8'hFF, 1'b1, 16'h0001, "s_FFxFF");
        run_op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_7Fx80");
        run_op8(8'hFF, 8'h01, 1'b1, 16'hFFFF, "s_FFx01");
        run_op8(8'h00, 8'hA5, 1'b0, 16'h0000, "u_00xA5");
    endtask

    task automatic test_backpressure;
        int          lat;
        logic [15:0] exp;
        iv8 = 1'b1;
        m8  = 8'h7F;
        q8  = 8'h80;
        s8  = 1'b1;
        sb8.push_back(16'hC080);
        tick();
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        exp = sb8.pop_front();
        or8 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            iv8 = i[0];
            m8  = 8'($urandom);
            q8  = 8'($urandom);
            checks++;
            if ({ov8, ir8, busy8, p8} !== {3'b100, exp}) begin
                errors++;
                $display("FAIL stall_%0d got ov=%b ir=%b busy=%b p=%h want ov=1 ir=0 busy=0 p=%h",
                         i, ov8, ir8, busy8, p8, exp);
            end
            tick();
        end
        iv8 = 1'b0;
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        checks++;
        if ({ir8, ov8, p8} !== {2'b10, exp}) begin
            errors++;
            $display("FAIL stall_release got ir=%b ov=%b p=%h want ir=1 ov=0 p=%h",
                     ir8, ov8, p8, exp);
        end
        tick();
        checks++;
        if ({ir8, busy8} !== 2'b10) begin
            errors++;
            $display("FAIL stall_no_ghost got ir=%b busy=%b want ir=1 busy=0", ir8, busy8);
        end
    endtask

    task automatic test_reset_mid;
        iv8 = 1'b1;
        m8  = 8'h12;
        q8  = 8'h34;
        s8  = 1'b0;
        tick();
        iv8 = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (busy8 !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy got %b want 1", busy8);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({ir8, ov8, busy8, p8} !== {3'b100, 16'h0000}) begin
            errors++;
            $display("FAIL midrst_state got ir=%b ov=%b busy=%b p=%h want ir=1 ov=0 busy=0 p=0000",
                     ir8, ov8, busy8, p8);
        end
        run_op8(8'h03, 8'h05, 1'b0, 16'h000F, "u_3x5_after_rst");
    endtask

    task automatic test_back_to_back;
        int          cyc, done, sent, last_acc;
        bit          prev_ov;
        logic [31:0] r, exp;
        cyc      = 0;
        done     = 0;
        sent     = 0;
        last_acc = 0;
        prev_ov  = 1'b0;
        while (done < 1000 && cyc < 60000) begin
            iv16 = (sent < 1000);
            m16  = 16'($urandom);
            q16  = 16'($urandom);
            s16  = 1'($urandom_range(0, 1));
            or16 = 1'($urandom_range(0, 1));
            if (ov16 && !prev_ov) begin
                checks++;
                if (cyc - last_acc != 17) begin
                    errors++;
                    $display("FAIL b2b_latency got %0d want 17", cyc - last_acc);
                end
            end
            prev_ov = ov16;
            if (iv16 && ir16) begin
                r = ref_mul(m16, q16, s16, 16);
                sb16.push_back(r);
                sent++;
                last_acc = cyc + 1;
            end
            if (ov16 && or16) begin
                checks++;
                if (sb16.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_output got p=%h want none", p16);
                end else begin
                    exp = sb16.pop_front();
                    if (p16 !== exp) begin
                        errors++;
                        $display("FAIL b2b_product_%0d got %h want %h", done, p16, exp);
                    end
                end
                done++;
            end
            tick();
            cyc++;
        end
        iv16 = 1'b0;
        or16 = 1'b0;
        checks++;
        if (done != 1000) begin
            errors++;
            $display("FAIL b2b_timeout got %0d results want 1000", done);
        end
    endtask

    initial begin
        rst  = 1'b1;
        iv8  = 1'b0;
        s8   = 1'b0;
        m8   = '0;
        q8   = '0;
        or8  = 1'b0;
        iv16 = 1'b0;
        s16  = 1'b0;
        m16  = '0;
        q16  = '0;
        or16 = 1'b0;
        test_reset();
        test_corners();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
